// File: rtl/pipelined_alu_stream.sv
// Streaming ALU: registered arithmetic/logic/compare/shift ops with per-beat flags and a saturating invalid-op counter.
// Latency: STAGES cycles from acceptance to out_valid; the op is computed in the first stage, later stages only delay it.
// Backpressure: every stage shifts together only when the output slot is empty or being taken; in_ready = advance && !rst.
// Optional: define ALU_SAT_EN to enable the unsigned saturating add/subtract opcodes (1100/1101).
module pipelined_alu_stream #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             invalid_op,
  output logic             is_equal,
  output logic             is_less,
  output logic [CNT_W-1:0] err_count
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_LTU  = 4'b1001;
  localparam logic [3:0] OP_LTS  = 4'b1010;
  localparam logic [3:0] OP_ASR  = 4'b1011;
  localparam logic [3:0] OP_SADD = 4'b1100;
  localparam logic [3:0] OP_SSUB = 4'b1101;

  // One beat's worth of output payload, carried through every stage.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             underflow;
    logic             invalid_op;
    logic             is_equal;
    logic             is_less;
  } res_t;

  res_t              calc;
  res_t              stg_dat [STAGES];
  logic [STAGES-1:0] stg_vld;
  logic              advance;

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  diff;
  logic              a_lt_b;
  logic              a_lts_b;
  logic [SH_W-1:0]   shamt;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;
  assign a_lt_b  = a < b;
  assign a_lts_b = $signed(a) < $signed(b);
  assign shamt   = b[SH_W-1:0];

  assign out_valid = stg_vld[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;

  // Stage-1 datapath: decode op and compute result plus flags; undefined flags stay 0.
  always_comb begin
    calc = '0;
    case (op)
      OP_ADD: begin
        calc.result   = sum[WIDTH-1:0];
        calc.overflow = sum[WIDTH];
      end
      OP_SUB: begin
        calc.result    = diff;
        calc.underflow = a_lt_b;
      end
      OP_AND: calc.result = a & b;
      OP_OR:  calc.result = a | b;
      OP_XOR: calc.result = a ^ b;
      OP_NOT: calc.result = ~a;
      OP_SHL: calc.result = a << shamt;
      OP_SHR: calc.result = a >> shamt;
      OP_ASR: calc.result = $signed(a) >>> shamt;
      OP_EQ:  calc.is_equal = (a == b);
      OP_LTU: calc.is_less  = a_lt_b;
      OP_LTS: calc.is_less  = a_lts_b;
`ifdef ALU_SAT_EN
      OP_SADD: begin
        calc.result   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        calc.overflow = sum[WIDTH];
      end
      OP_SSUB: begin
        calc.result    = a_lt_b ? '0 : diff;
        calc.underflow = a_lt_b;
      end
`else
      OP_SADD, OP_SSUB: calc.invalid_op = 1'b1;
`endif
      default: calc.invalid_op = 1'b1;
    endcase
  end

  // Lock-step pipeline shift; bubbles enter as all-zero payload so idle slots carry no stale flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      for (int i = 0; i < STAGES; i++) stg_dat[i] <= '0;
    end else if (advance) begin
      stg_vld[0] <= in_valid;
      stg_dat[0] <= in_valid ? calc : '0;
      for (int i = 1; i < STAGES; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  // Count retired invalid beats, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && stg_dat[STAGES-1].invalid_op && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  assign result     = stg_dat[STAGES-1].result;
  assign overflow   = stg_dat[STAGES-1].overflow;
  assign underflow  = stg_dat[STAGES-1].underflow;
  assign invalid_op = stg_dat[STAGES-1].invalid_op;
  assign is_equal   = stg_dat[STAGES-1].is_equal;
  assign is_less    = stg_dat[STAGES-1].is_less;

endmodule

// File: doc/pipelined_alu_stream.md
PIPELINED_ALU_STREAM -- requirements
Module: pipelined_alu_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, legal 8..64, power of two.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth in cycles, legal 1..4.
REQ-003 SHALL have parameter CNT_W, default 8: width of err_count.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1: operand beat valid.
REQ-007 SHALL have port in_ready  out  1: block can accept a beat.
REQ-008 SHALL have ports a, b  in  WIDTH: operands, unsigned unless the op states signed.
REQ-009 SHALL have port op  in  4: opcode.
REQ-010 SHALL have port out_valid  out  1: result beat valid.
REQ-011 SHALL have port out_ready  in  1: downstream accepts result.
REQ-012 SHALL have port result  out  WIDTH: operation result.
REQ-013 SHALL have ports overflow, underflow, invalid_op, is_equal, is_less  out  1 each: per-beat flags.
REQ-014 SHALL have port err_count  out  CNT_W: count of retired invalid ops.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready, and retire one when out_valid && out_ready.
REQ-016 SHALL drive advance = !out_valid || out_ready, and in_ready = advance && !rst.
REQ-017 SHALL shift all STAGES stages together only on advance; empty slots travel as bubbles (valid=0).
REQ-018 SHALL deliver each beat on out_valid exactly STAGES cycles after acceptance when out_ready is held high; order preserved, no drops, no duplicates.
REQ-019 SHALL hold result and flags stable while out_valid && !out_ready.
REQ-020 SHALL have no combinational path from a/b/op/in_valid to any output; out_ready -> in_ready is combinational.
REQ-021 SHALL compute in stage 1; later stages are pure delay registers.
REQ-022 Opcodes: 0000 ADD (overflow = carry out); 0001 SUB (wrap; underflow = a<b unsigned); 0010 AND; 0011 OR; 0100 XOR; 0101 NOT a.
REQ-023 Opcodes: 0110 SHL a by b[log2(WIDTH)-1:0]; 0111 SHR logical, same amount; 1011 ASR signed, same amount; a shift amount of 0 returns a.
REQ-024 Opcodes: 1000 EQ (is_equal = a==b); 1001 LTU (is_less unsigned); 1010 LTS (is_less, two's-complement); compares return result=0.
REQ-025 Opcodes 1100 SADD / 1101 SSUB per REQ-032/033; 1110, 1111 SHALL give result=0, invalid_op=1.
REQ-026 Each beat SHALL carry all flags; flags not defined for that op SHALL be 0.
REQ-027 err_count SHALL increment on each retired beat with invalid_op=1 and saturate at all-ones, never wrapping.

Reset
REQ-028 SHALL clear, when rst is high at a clock edge, all stage valid bits, result, all flags and err_count to 0.
REQ-029 SHALL discard in-flight beats on reset mid-operation; they are never delivered.
REQ-030 SHALL hold in_ready at 0 while rst is high; in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-031 SHALL ignore in_valid and out_ready while rst is high.

Configuration
REQ-032 With ALU_SAT_EN defined: 1100 = unsigned saturating add (clamp to all-ones, overflow=1 on clamp); 1101 = unsigned saturating subtract (clamp to 0, underflow=1 on clamp).
REQ-033 Without ALU_SAT_EN: 1100 and 1101 SHALL behave as invalid (result=0, invalid_op=1, counted).

Verification
REQ-034 WIDTH=16, STAGES=2, out_ready=1: ADD a=FFFF b=0001 -> 2 cycles later result=0000, overflow=1; SUB a=0003 b=0005 -> result=FFFE, underflow=1.
REQ-035 Back-to-back stream of 10 ADDs, out_ready pulsed 0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held, all 10 results in order, none lost.
REQ-036 LTS a=8000 b=0001 -> is_less=1; LTU same operands -> is_less=0; ASR a=8000 b=0004 -> F800.
REQ-037 CNT_W=2: five beats with op=1111 -> err_count 1,2,3,3,3; each invalid_op=1, result=0.
REQ-038 ALU_SAT_EN defined: SADD FFF0+0020 -> FFFF, overflow=1; undefined: same beat -> invalid_op=1. Assert rst with 2 beats in flight -> no out_valid afterwards, err_count=0.
